// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Owns the PC, issues word fetches to instruction
//   memory over a req/ready handshake and hands instr/PC/valid to IF/ID.
//   Absorbs hazard-unit stalls and branch/jump redirects from ID.
//
// Ports
//   clk, rst        clock (posedge) and asynchronous active-low reset
//   stall           hazard-unit stall; IF neither advances nor delivers
//   br_taken/br_target, jump/jump_target
//                   ID-stage redirects (jump has priority)
//   imem_req/imem_addr   fetch request and its word address
//   imem_ready/imem_rdata  completion strobe and fetched word
//   if_instr/if_pc/if_valid  registered outputs to IF/ID
//   fetch_busy      request outstanding and not yet ready
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  localparam int unsigned AW = 30,
  localparam int unsigned IW = 32,
  parameter logic [AW-1:0] RESET_PC  = 30'h0000_0C00,
  parameter logic [IW-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic          fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic [IW-1:0]   hold_instr_q, hold_instr_d;
  logic [AW-1:0]   hold_pc_q, hold_pc_d;
  logic [IW-1:0]   if_instr_q, if_instr_d;
  logic [AW-1:0]   if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;

  logic            redirect;
  logic [AW-1:0]   target;
  logic            deliver;
  logic [IW-1:0]   deliver_instr;
  logic [AW-1:0]   deliver_pc;

  assign redirect = jump | br_taken;
  assign target   = jump ? jump_target : br_target;

  // Request is gated by rst so an in-flight fetch is abandoned the instant reset asserts.
  assign imem_req   = rst & (state_q != S_HOLD);
  assign imem_addr  = req_addr_q;
  assign fetch_busy = imem_req & ~imem_ready;

  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= RESET_PC;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= RESET_PC;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_valid_q   <= if_valid_d;
    end
  end

  // Next-state, fetch sequencing and output-register update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;
    deliver       = 1'b0;
    deliver_instr = NOP_INSTR;
    deliver_pc    = if_pc_q;

    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d       = target;
            req_addr_d = target;
          end else if (!stall) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            deliver_pc    = req_addr_q;
            pc_d          = AW'(req_addr_q + AW'(1));
            req_addr_d    = AW'(req_addr_q + AW'(1));
          end else begin
            // Word arrived while stalled: park it so it is not lost or refetched.
            hold_instr_d = imem_rdata;
            hold_pc_d    = req_addr_q;
            pc_d         = AW'(req_addr_q + AW'(1));
            state_d      = S_HOLD;
          end
        end else if (redirect) begin
          // The bus request cannot be withdrawn; remember the target and drain it.
          pc_d    = target;
          state_d = S_DROP;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d       = target;
          req_addr_d = target;
          state_d    = S_FETCH;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc    = hold_pc_q;
          pc_d          = AW'(hold_pc_q + AW'(1));
          req_addr_d    = AW'(hold_pc_q + AW'(1));
          state_d       = S_FETCH;
        end
      end

      S_DROP: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ready) begin
          // A redirect landing with the final ready must still win.
          req_addr_d = redirect ? target : pc_q;
          state_d    = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Outputs freeze under stall; otherwise either a delivery or a bubble.
    if (!stall) begin
      if (deliver) begin
        if_instr_d = deliver_instr;
        if_pc_d    = deliver_pc;
        if_valid_d = 1'b1;
      end else begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
    end
  end

endmodule
